// File: rtl/fixed_to_float.sv
// Multi-cycle conversion of a signed 32-bit fixed-point value into IEEE-754 single precision.
// The leading one is found by shifting the magnitude left one bit per cycle.
module fixed_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fixed,
    input  logic [4:0]  fixpointpos,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    typedef enum logic [2:0] {IDLE, ABS, NORM, PACK, DONE} state_t;

    state_t      state_q,  state_d;
    logic [31:0] fixed_q,  fixed_d;
    logic [4:0]  fp_q,     fp_d;
    logic        sign_q,   sign_d;
    logic [31:0] mag_q,    mag_d;
    logic [4:0]  count_q,  count_d;
    logic        zero_q,   zero_d;
    logic [31:0] result_q, result_d;
    logic [7:0]  exponent;

    // Leading-one position is 31 - count, so exponent = 158 - count - fixpointpos.
    assign exponent = 8'd158 - {3'b000, count_q} - {3'b000, fp_q};

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d  = state_q;
        fixed_d  = fixed_q;
        fp_d     = fp_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        count_d  = count_q;
        zero_d   = zero_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    fixed_d = fixed;
                    fp_d    = fixpointpos;
                    state_d = ABS;
                end
            end
            ABS: begin
                sign_d  = fixed_q[31];
                mag_d   = fixed_q[31] ? (~fixed_q + 32'd1) : fixed_q;
                zero_d  = (fixed_q == 32'd0);
                count_d = 5'd0;
                state_d = (fixed_q == 32'd0) ? PACK : NORM;
            end
            NORM: begin
                if (mag_q[31]) begin
                    state_d = PACK;
                end else begin
                    mag_d   = {mag_q[30:0], 1'b0};
                    count_d = count_q + 5'd1;
                end
            end
            PACK: begin
                result_d = zero_q ? 32'd0 : {sign_q, exponent, mag_q[30:8]};
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            fixed_q  <= 32'd0;
            fp_q     <= 5'd0;
            sign_q   <= 1'b0;
            mag_q    <= 32'd0;
            count_q  <= 5'd0;
            zero_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            fixed_q  <= fixed_d;
            fp_q     <= fp_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            count_q  <= count_d;
            zero_q   <= zero_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_fixed_to_float.sv
// Self-checking bench for fixed_to_float: vector table, random vectors against a
// reference model, stall, reset-abort and back-to-back sequences, scoreboard-ordered.
module tb_fixed_to_float;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] fixed = 32'd0;
    logic [4:0]  fixpointpos = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] fixed;
        logic [4:0]  fp;
        logic [31:0] result;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        int          lat;
    } exp_t;

    exp_t sb[$];

    fixed_to_float dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .fixed       (fixed),
        .fixpointpos (fixpointpos),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: locate the leading one by scanning, then scale the mantissa by shifting.
    function automatic exp_t model(input logic [31:0] f, input logic [4:0] fp);
        exp_t        e;
        logic [31:0] mag;
        int          p;
        int          ex;
        logic [31:0] mant;
        mag = f[31] ? (32'd0 - f) : f;
        if (mag == 32'd0) begin
            e.result = 32'd0;
            e.lat    = 2;
            return e;
        end
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        ex = p - int'(fp) + 127;
        if (p >= 23) mant = (mag >> (p - 23)) & 32'h007F_FFFF;
        else         mant = (mag << (23 - p)) & 32'h007F_FFFF;
        e.result = {f[31], 8'(ex), mant[22:0]};
        e.lat    = 3 + (31 - p);
        return e;
    endfunction

    // Waits (bounded) for out_valid after an accept edge; returns edges counted.
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 60);
    endtask

    task automatic drive_accept(input logic [31:0] f, input logic [4:0] p, input string tag);
        int n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        fixed       = f;
        fixpointpos = p;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        fixed       = $urandom;
        fixpointpos = 5'($urandom);
    endtask

    task automatic run_one(input logic [31:0] f, input logic [4:0] p, input logic [31:0] er,
                           input int el, input string tag);
        exp_t e;
        int   lat;
        e.result = er;
        e.lat    = el;
        sb.push_back(e);
        drive_accept(f, p, tag);
        wait_out(lat);
        e = sb.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " result"}, result, e.result);
        @(posedge clk); #1;
        check({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
        check({tag, " result retained"}, result, e.result);
    endtask

    task automatic run_stall(input logic [31:0] f, input logic [4:0] p, input string tag);
        exp_t e;
        int   lat;
        e = model(f, p);
        sb.push_back(e);
        out_ready = 1'b0;
        drive_accept(f, p, tag);
        wait_out(lat);
        e = sb.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " result"}, result, e.result);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            fixed    = $urandom;
            @(posedge clk); #1;
            check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " stall result"}, result, e.result);
            check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " released out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " released in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[10];
        exp_t e;
        int   lat;
        int   n;

        vecs[0] = '{32'h0000_0100, 5'd8,  32'h3F80_0000, 26};
        vecs[1] = '{32'hFFFF_FF00, 5'd8,  32'hBF80_0000, 26};
        vecs[2] = '{32'h8000_0000, 5'd0,  32'hCF00_0000, 3};
        vecs[3] = '{32'h7FFF_FFFF, 5'd0,  32'h4EFF_FFFF, 4};
        vecs[4] = '{32'h0000_0003, 5'd31, 32'h30C0_0000, 33};
        vecs[5] = '{32'h0000_0000, 5'd5,  32'h0000_0000, 2};
        vecs[6] = '{32'h0000_0001, 5'd0,  32'h3F80_0000, 34};
        vecs[7] = '{32'hFFFF_FFFF, 5'd0,  32'hBF80_0000, 34};
        vecs[8] = '{32'h0000_0006, 5'd1,  32'h4040_0000, 32};
        vecs[9] = '{32'h0123_4567, 5'd0,  32'h4B91_A2B3, 10};

        // Reset state.
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            run_one(vecs[i].fixed, vecs[i].fp, vecs[i].result, vecs[i].lat, $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            logic [31:0] f;
            logic [4:0]  p;
            f = $urandom;
            if (i == 3) f = f >> 20;
            p = 5'($urandom_range(0, 31));
            e = model(f, p);
            run_one(f, p, e.result, e.lat, $sformatf("rand%0d", i));
        end

        run_stall(32'h0000_0000, 5'd17, "stall_zero");
        run_stall(32'hFFFF_FF00, 5'd8, "stall_neg");

        // Reset mid-NORM: previous result is nonzero, so clearing is visible.
        drive_accept(32'h0000_0001, 5'd0, "abort");
        repeat (10) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort result", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_one(32'h0000_0100, 5'd8, 32'h3F80_0000, 26, "post_reset");
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        check("no spurious out_valid", 32'(n), 32'd0);

        // Back-to-back with in_valid held high.
        sb.push_back(model(32'h0000_0100, 5'd8));
        sb.push_back(model(32'h8000_0000, 5'd0));
        fixed       = 32'h0000_0100;
        fixpointpos = 5'd8;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        fixed       = 32'h8000_0000;
        fixpointpos = 5'd0;
        wait_out(lat);
        e = sb.pop_front();
        check("b2b first latency", 32'(lat), 32'(e.lat));
        check("b2b first result", result, e.result);
        @(posedge clk); #1;
        check("b2b idle in_ready", 32'(in_ready), 32'd1);
        check("b2b idle out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("b2b second accepted", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_out(lat);
        e = sb.pop_front();
        check("b2b second latency", 32'(lat), 32'(e.lat));
        check("b2b second result", result, e.result);
        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
